// File: rtl/adc_seq_controller.sv
// Sequencer for NUM_CH parallel serial SAR ADCs sharing CNVST/SCLK/CS/RESET:
// reset handshake, conversion trigger, MSB-first readback and sticky error capture.
module adc_seq_controller #(
  parameter int NUM_CH    = 4,
  parameter int RAW_BITS  = 18,
  parameter int OUT_BITS  = 16,
  parameter int SCLK_HALF = 1,
  parameter int T_CYCLE   = 119,
  parameter int T_RESET   = 3,
  parameter int T_TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       clear_error,
  input  logic [NUM_CH-1:0]          SDOUT,
  input  logic [NUM_CH-1:0]          BUSY,
  input  logic [NUM_CH-1:0]          RDERROR,
  output logic [NUM_CH*OUT_BITS-1:0] data_out,
  output logic                       data_valid,
  output logic                       ready,
  output logic                       error,
  output logic [1:0]                 error_code,
  output logic                       SCLK,
  output logic                       CNVST,
  output logic                       CS,
  output logic                       RESET,
  output logic                       RD,
  output logic                       OB2C,
  output logic                       PD
);

  localparam int CYC_W  = $clog2(T_CYCLE + 1);
  localparam int TO_W   = $clog2(T_TIMEOUT + 1);
  localparam int RST_W  = $clog2(T_RESET + 1);
  localparam int SCLK_W = $clog2(SCLK_HALF + 1);
  localparam int IDX_W  = $clog2(RAW_BITS);

  localparam logic [CYC_W-1:0]  CYC_MAX   = CYC_W'(T_CYCLE);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(T_CYCLE - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(T_TIMEOUT);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(T_RESET - 1);
  localparam logic [SCLK_W-1:0] SCLK_LAST = SCLK_W'(SCLK_HALF - 1);
  localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(RAW_BITS - 1);

  typedef enum logic [3:0] {
    ST_RESETTING,
    ST_RST_WAIT_UP,
    ST_RST_WAIT_DOWN,
    ST_READY,
    ST_CNV_WAIT_UP,
    ST_CNV_WAIT_DOWN,
    ST_SHIFT,
    ST_HOLD,
    ST_ERROR
  } state_t;

  state_t                           state_q, state_d;
  logic [RST_W-1:0]                 rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]                 cyc_cnt_q, cyc_cnt_d;
  logic [TO_W-1:0]                  to_cnt_q, to_cnt_d;
  logic [SCLK_W-1:0]                sclk_cnt_q, sclk_cnt_d;
  logic [IDX_W-1:0]                 bit_idx_q, bit_idx_d;
  logic [NUM_CH-1:0][RAW_BITS-1:0]  shift_q, shift_d;
  logic [NUM_CH-1:0][RAW_BITS-1:0]  word_now;
  logic [NUM_CH*OUT_BITS-1:0]       msb_now;
  logic [RAW_BITS-1:0]              bit_mask;
  logic [NUM_CH*OUT_BITS-1:0]       data_d;
  logic                             valid_d, error_d;
  logic [1:0]                       code_d;
  logic                             sclk_d, cnvst_d, cs_d, reset_d;
  logic                             busy_any, timeout;

  assign busy_any = |BUSY;
  assign ready    = (state_q == ST_READY);
  assign RD       = 1'b0;
  assign OB2C     = 1'b0;
  assign PD       = 1'b0;

  // Each channel's word with the bit currently on SDOUT merged in, so the
  // final sample can be published in the same cycle it is taken.
  assign bit_mask = {{(RAW_BITS-1){1'b0}}, 1'b1} << bit_idx_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign word_now[g] = SDOUT[g] ? (shift_q[g] | bit_mask) : (shift_q[g] & ~bit_mask);
    assign msb_now[g*OUT_BITS +: OUT_BITS] = word_now[g][RAW_BITS-1 -: OUT_BITS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESETTING;
      rst_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      to_cnt_q   <= '0;
      sclk_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'd0;
      RESET      <= 1'b1;
      CNVST      <= 1'b1;
      CS         <= 1'b1;
      SCLK       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sclk_cnt_q <= sclk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      error      <= error_d;
      error_code <= code_d;
      RESET      <= reset_d;
      CNVST      <= cnvst_d;
      CS         <= cs_d;
      SCLK       <= sclk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cyc_cnt_d  = (cyc_cnt_q == CYC_MAX) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
    to_cnt_d   = to_cnt_q;
    sclk_cnt_d = sclk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_out;
    valid_d    = 1'b0;
    error_d    = error;
    code_d     = error_code;
    sclk_d     = SCLK;
    cnvst_d    = CNVST;
    cs_d       = CS;
    reset_d    = RESET;
    timeout    = 1'b0;

    case (state_q)
      ST_RESETTING: begin
        reset_d = 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          reset_d  = 1'b0;
          to_cnt_d = '0;
          state_d  = ST_RST_WAIT_UP;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RST_WAIT_UP: begin
        if (busy_any) begin
          to_cnt_d = '0;
          state_d  = ST_RST_WAIT_DOWN;
        end else if (to_cnt_q == TO_MAX) timeout = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end
      ST_RST_WAIT_DOWN: begin
        if (!busy_any) state_d = ST_READY;
        else if (to_cnt_q == TO_MAX) timeout = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end
      ST_READY: begin
        if (start || continuous) begin
          cnvst_d   = 1'b0;
          cyc_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_CNV_WAIT_UP;
        end
      end
      ST_CNV_WAIT_UP: begin
        if (busy_any) begin
          cnvst_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_CNV_WAIT_DOWN;
        end else if (to_cnt_q == TO_MAX) timeout = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end
      ST_CNV_WAIT_DOWN: begin
        if (!busy_any) begin
          cs_d       = 1'b0;
          sclk_d     = 1'b1;
          sclk_cnt_d = '0;
          bit_idx_d  = IDX_MSB;
          state_d    = ST_SHIFT;
        end else if (to_cnt_q == TO_MAX) timeout = 1'b1;
        else to_cnt_d = to_cnt_q + 1'b1;
      end
      ST_SHIFT: begin
        if (sclk_cnt_q == SCLK_LAST) begin
          sclk_cnt_d = '0;
          sclk_d     = ~SCLK;
          if (!SCLK) begin
            shift_d = word_now;
            if (bit_idx_q == '0) begin
              cs_d    = 1'b1;
              sclk_d  = 1'b1;
              data_d  = msb_now;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end else begin
              bit_idx_d = bit_idx_q - 1'b1;
            end
          end
        end else begin
          sclk_cnt_d = sclk_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        // Leaving one count early makes READY re-trigger on the edge where
        // the count reaches T_CYCLE, giving a T_CYCLE+1 trigger period.
        if (cyc_cnt_q >= CYC_LAST) state_d = ST_READY;
      end
      ST_ERROR: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        cnvst_d = 1'b1;
        if (clear_error) begin
          reset_d   = 1'b1;
          rst_cnt_d = '0;
          error_d   = 1'b0;
          code_d    = 2'd0;
          state_d   = ST_RESETTING;
        end
      end
      default: state_d = ST_RESETTING;
    endcase

    if (state_q != ST_ERROR) begin
      if ((|RDERROR) || timeout || (start && !continuous && state_q != ST_READY)) begin
        state_d = ST_ERROR;
        error_d = 1'b1;
        if (|RDERROR)     code_d = 2'd1;
        else if (timeout) code_d = 2'd3;
        else              code_d = 2'd2;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        cnvst_d = 1'b1;
        valid_d = 1'b0;
        data_d  = data_out;
      end
    end
  end

endmodule

// File: tb/tb_adc_seq_controller.sv
// Directed bench for adc_seq_controller with a behavioural 4-channel ADC model
// (BUSY pulse after RESET/CNVST falls, MSB-first SDOUT on SCLK falling edges).
module tb_adc_seq_controller;

  localparam int NUM_CH    = 4;
  localparam int RAW_BITS  = 18;
  localparam int OUT_BITS  = 16;
  localparam int T_CYCLE   = 119;
  localparam int T_RESET   = 3;
  localparam int T_TIMEOUT = 1023;

  localparam int SEL_READY = 0;
  localparam int SEL_CS    = 1;
  localparam int SEL_CNVST = 2;
  localparam int SEL_DV    = 3;
  localparam int SEL_RESET = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic clear_error = 1'b0;
  logic [NUM_CH-1:0] SDOUT = '0;
  logic [NUM_CH-1:0] BUSY;
  logic [NUM_CH-1:0] RDERROR = '0;
  logic [NUM_CH*OUT_BITS-1:0] data_out;
  logic data_valid, ready, error;
  logic [1:0] error_code;
  logic SCLK, CNVST, CS, RESET, RD, OB2C, PD;

  adc_seq_controller #(
    .NUM_CH(NUM_CH), .RAW_BITS(RAW_BITS), .OUT_BITS(OUT_BITS), .SCLK_HALF(1),
    .T_CYCLE(T_CYCLE), .T_RESET(T_RESET), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .clear_error(clear_error), .SDOUT(SDOUT), .BUSY(BUSY), .RDERROR(RDERROR),
    .data_out(data_out), .data_valid(data_valid), .ready(ready), .error(error),
    .error_code(error_code), .SCLK(SCLK), .CNVST(CNVST), .CS(CS), .RESET(RESET),
    .RD(RD), .OB2C(OB2C), .PD(PD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ADC model
  logic [RAW_BITS-1:0] word [NUM_CH];
  logic [NUM_CH-1:0] busy_m = '0;
  logic busy_stuck = 1'b0;
  assign BUSY = busy_m | {NUM_CH{busy_stuck}};

  int rises = 0;
  always @(negedge CS) rises = 0;
  always @(posedge SCLK) rises++;
  always @(negedge SCLK) begin
    if (rises < RAW_BITS) begin
      for (int k = 0; k < NUM_CH; k++) begin
        logic [RAW_BITS-1:0] t;
        t = word[k] << rises;
        SDOUT[k] = t[RAW_BITS-1];
      end
    end
  end

  // Staggered BUSY release so the controller must wait for every channel.
  always begin
    @(negedge RESET or negedge CNVST);
    repeat (2) @(negedge clk);
    busy_m = '1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      busy_m[k] = 1'b0;
      @(negedge clk);
    end
  end

  int cyc = 0;
  int falls[$];
  int dv_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge CNVST) falls.push_back(cyc);
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  function automatic logic sig(input int sel);
    case (sel)
      SEL_READY: return ready;
      SEL_CS:    return CS;
      SEL_CNVST: return CNVST;
      SEL_DV:    return data_valid;
      SEL_RESET: return RESET;
      default:   return 1'bx;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic val, input int limit);
    int n;
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, sig(sel), val);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_and_recover(input string tag);
    busy_stuck = 1'b0;
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    wait_for({tag, "_ready"}, SEL_READY, 1'b1, 300);
  endtask

  task automatic run_frame(input string tag, input logic [RAW_BITS-1:0] w0, w1, w2, w3,
                           input logic [63:0] exp);
    word[0] = w0; word[1] = w1; word[2] = w2; word[3] = w3;
    pulse_start();
    wait_for({tag, "_valid"}, SEL_DV, 1'b1, 300);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_sclk_rises"}, rises, RAW_BITS);
    check({tag, "_cs_sclk"}, {CS, SCLK}, 2'b11);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, data_valid, 1'b0);
    wait_for({tag, "_ready"}, SEL_READY, 1'b1, 300);
    check({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NUM_CH; k++) word[k] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pins", {RESET, CNVST, CS, SCLK}, 4'hF);
    check("rst_data", data_out, 64'h0);
    check("rst_flags", {data_valid, ready, error, error_code}, 5'b0);
    check("tied_low", {RD, OB2C, PD}, 3'b0);
    reset = 1'b0;
    wait_for("reset_pin_fall", SEL_RESET, 1'b0, 20);
    wait_for("ready_after_reset", SEL_READY, 1'b1, 300);

    // single frames
    run_frame("f1", 18'h2AAAA, 18'h2AAAB, 18'h2AAAC, 18'h2AAAD, 64'hAAAB_AAAB_AAAA_AAAA);
    run_frame("f2", 18'h3FFFC, 18'h00003, 18'h12345, 18'h2ABCD, 64'hAAF3_48D1_0000_FFFF);

    // continuous: 10 frames, then drop continuous mid-frame
    falls.delete();
    dv_cnt = 0;
    continuous = 1'b1;
    n = 0;
    while (falls.size() < 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    wait_for("cont_ready", SEL_READY, 1'b1, 300);
    repeat (150) @(negedge clk);
    check("cont_falls", falls.size(), 10);
    check("cont_valids", dv_cnt, 10);
    for (int i = 1; i < 10 && i < falls.size(); i++)
      check($sformatf("cont_gap%0d", i), falls[i] - falls[i-1], T_CYCLE + 1);

    // start during SHIFT
    dv_cnt = 0;
    pulse_start();
    wait_for("e2_shift", SEL_CS, 1'b0, 100);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("e2_flag", {error, error_code}, 3'b110);
    check("e2_pins", {CS, SCLK, CNVST}, 3'b111);
    RDERROR = 4'b0001;
    repeat (3) @(negedge clk);
    RDERROR = '0;
    check("e2_frozen", {error, error_code, ready}, 4'b1100);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clr_flags", {error, error_code}, 3'b000);
    n = 0;
    while (RESET === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("clr_reset_len", n, T_RESET);
    wait_for("clr_ready", SEL_READY, 1'b1, 300);
    check("e2_no_valid", dv_cnt, 0);

    // BUSY stuck high: timeout
    busy_stuck = 1'b1;
    pulse_start();
    wait_for("to_cnvst_hi", SEL_CNVST, 1'b1, 10);
    repeat (T_TIMEOUT) @(negedge clk);
    check("to_not_yet", error, 1'b0);
    @(negedge clk);
    check("to_code", {error, error_code}, 3'b111);
    clear_and_recover("to");

    // RDERROR[2] + timeout + start in the same cycle -> code 1
    busy_stuck = 1'b1;
    pulse_start();
    wait_for("p1_cnvst_hi", SEL_CNVST, 1'b1, 10);
    repeat (T_TIMEOUT) @(negedge clk);
    RDERROR = 4'b0100;
    start = 1'b1;
    @(negedge clk);
    RDERROR = '0;
    start = 1'b0;
    check("prio_rderr", {error, error_code}, 3'b101);
    clear_and_recover("p1");

    // timeout + start in the same cycle -> code 3
    busy_stuck = 1'b1;
    pulse_start();
    wait_for("p3_cnvst_hi", SEL_CNVST, 1'b1, 10);
    repeat (T_TIMEOUT) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("prio_timeout", {error, error_code}, 3'b111);
    clear_and_recover("p3");

    // reset mid-SHIFT aborts the frame
    dv_cnt = 0;
    word[0] = 18'h2AAAA;
    pulse_start();
    wait_for("ab_shift", SEL_CS, 1'b0, 100);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ab_pins", {CS, SCLK, RESET, CNVST}, 4'hF);
    check("ab_state", {data_valid, data_out}, 65'h0);
    reset = 1'b0;
    wait_for("ab_ready", SEL_READY, 1'b1, 300);
    repeat (20) @(negedge clk);
    check("ab_no_valid", dv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
